// File: rtl/rr_grant_pkg.sv
// rr_grant_pkg: shared types, defaults and the round-robin pick function for rr_grant_ctrl.
//   state_e  : arbiter state (StIdle = no grant, StBusy = grant held)
//   rr_pick  : index of the first set request bit searching ptr, ptr+1, .., n-1, 0, .., ptr-1
package rr_grant_pkg;

  typedef enum logic {StIdle, StBusy} state_e;

  localparam int unsigned DefaultN       = 4;
  localparam int unsigned DefaultTimeout = 64;
  localparam int unsigned MaxN           = 16;
  localparam int unsigned MaxIw          = 4;

  // Requests are zero-extended to MaxN bits so one function serves every N.
  // Returns 0 when no bit is set; callers only use the result when a request exists.
  function automatic logic [MaxIw-1:0] rr_pick(input logic [MaxN-1:0]  req,
                                               input logic [MaxIw-1:0] ptr,
                                               input int unsigned      n);
    logic [MaxIw-1:0] win;
    logic [MaxIw-1:0] idx_b;
    logic             found;
    int unsigned      pos;
    win   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MaxN; off++) begin
      pos   = (32'(ptr) + off) % n;
      idx_b = pos[MaxIw-1:0];
      if (!found && (off < n) && req[idx_b]) begin
        win   = idx_b;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_onehot_dec.sv
// rr_onehot_dec: index + enable to one-hot decoder.
//   idx_i    : index to decode
//   en_i     : when low, all outputs are zero
//   onehot_o : N-bit one-hot (or all-zero) select
module rr_onehot_dec
  import rr_grant_pkg::*;
#(
  parameter int unsigned N  = DefaultN,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [IW-1:0] idx_i,
  input  logic          en_i,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin arbiter granting one shared resource among N requesters.
// A winner keeps the grant until it drops its request; the priority pointer then moves
// to the requester after it. Optional feature macro: RR_GRANT_TIMEOUT_EN (forced release
// after TIMEOUT busy cycles, with a one-cycle timeout pulse).
//   clk         : clock, rising edge
//   reset       : asynchronous reset, active high
//   req         : level requests, one bit per requester
//   grant       : one-hot grant, zero when idle
//   grant_idx   : index of current winner, meaningful while grant_valid is high
//   grant_valid : a grant is active
//   timeout     : one-cycle pulse on forced release (RR_GRANT_TIMEOUT_EN only)
module rr_grant_ctrl
  import rr_grant_pkg::*;
#(
  parameter int unsigned N       = DefaultN,
  parameter int unsigned IW      = $clog2(N),
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
`ifdef RR_GRANT_TIMEOUT_EN
  ,
  output logic          timeout
`endif
);

  if ((N < 2) || (N > MaxN) || (TIMEOUT < 2)) begin : gen_bad_param
    $error("rr_grant_ctrl: N must be 2..16 and TIMEOUT at least 2");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  req_elig;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_after;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic [N-1:0]  blocked_q, blocked_d;

  // A forced-off requester stays out of arbitration until it drops its bit.
  assign req_elig = req & ~blocked_q;
`else
  assign req_elig = req;
`endif

  assign pick_idx  = IW'(rr_pick(MaxN'(req_elig), MaxIw'(ptr_q), N));
  assign ptr_after = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
`ifdef RR_GRANT_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = 1'b0;
    blocked_d = blocked_q & req;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req_elig) begin
          state_d = StBusy;
          idx_d   = pick_idx;
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        // A release wins over a timeout in the same cycle.
        if (!req[idx_q]) begin
          state_d = StIdle;
          ptr_d   = ptr_after;
        end
`ifdef RR_GRANT_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d          = StIdle;
          ptr_d            = ptr_after;
          to_d             = 1'b1;
          blocked_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RR_GRANT_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      to_q      <= 1'b0;
      blocked_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      blocked_q <= blocked_d;
    end
  end

  assign timeout = to_q;
`endif

  assign grant_valid = (state_q == StBusy);
  assign grant_idx   = idx_q;

  rr_onehot_dec #(
    .N  (N),
    .IW (IW)
  ) u_dec (
    .idx_i    (idx_q),
    .en_i     (grant_valid),
    .onehot_o (grant)
  );

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: self-checking bench for rr_grant_ctrl with N=4 (TIMEOUT=8 when the
// RR_GRANT_TIMEOUT_EN build is used).
module tb_rr_grant_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
`ifdef RR_GRANT_TIMEOUT_EN
  logic          timeout;
`endif

  always #5 clk = ~clk;

  rr_grant_ctrl #(
    .N       (N),
    .IW      (IW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
`ifdef RR_GRANT_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [IW-1:0] idx;
    logic          valid;
    logic          to;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] req;
    exp_t         exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [N-1:0] r, input logic [N-1:0] g, input logic [IW-1:0] i,
                     input logic v);
    vec_t x;
    x.req       = r;
    x.exp.grant = g;
    x.exp.idx   = i;
    x.exp.valid = v;
    x.exp.to    = 1'b0;
    vecs.push_back(x);
  endtask

  // Drive one cycle of request, queue its expectation, compare after the edge.
  task automatic step(input logic [N-1:0] r, input exp_t e);
    exp_t x;
    sb.push_back(e);
    req = r;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("grant", 32'(grant), 32'(x.grant));
    check("grant_valid", 32'(grant_valid), 32'(x.valid));
    if (x.valid) check("grant_idx", 32'(grant_idx), 32'(x.idx));
    check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
`ifdef RR_GRANT_TIMEOUT_EN
    check("timeout", 32'(timeout), 32'(x.to));
`endif
  endtask

  function automatic exp_t mk(input logic [N-1:0] g, input logic [IW-1:0] i, input logic v,
                              input logic t);
    exp_t e;
    e.grant = g;
    e.idx   = i;
    e.valid = v;
    e.to    = t;
    return e;
  endfunction

  initial begin
    reset = 1'b1;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_valid", 32'(grant_valid), 32'd0);
    check("reset_idx", 32'(grant_idx), 32'd0);
`ifdef RR_GRANT_TIMEOUT_EN
    check("reset_timeout", 32'(timeout), 32'd0);
`endif
    reset = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // ptr=0: 1010 -> 1; release -> ptr=2 -> 3; release -> ptr wraps to 0.
    add(4'b1010, 4'b0010, 2'd1, 1'b1);
    add(4'b1010, 4'b0010, 2'd1, 1'b1);
    add(4'b1000, 4'b0000, 2'd0, 1'b0);
    add(4'b1000, 4'b1000, 2'd3, 1'b1);
    add(4'b1000, 4'b1000, 2'd3, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // All requesting; each winner holds 3 cycles then drops its own bit for one cycle.
    for (int w = 0; w < 4; w++) begin
      add(4'b1111, 4'(1 << w), 2'(w), 1'b1);
      add(4'b1111, 4'(1 << w), 2'(w), 1'b1);
      add(4'b1111, 4'(1 << w), 2'(w), 1'b1);
      add(4'b1111 & ~4'(1 << w), 4'b0000, 2'd0, 1'b0);
    end
    add(4'b1111, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // ptr=1: winner 3, then wrap to 0 so 1001 picks 0.
    add(4'b1000, 4'b1000, 2'd3, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    add(4'b1001, 4'b0001, 2'd0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);
    // ptr=1 -> grant 1 -> ptr=2.
    add(4'b0010, 4'b0010, 2'd1, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0);

    foreach (vecs[i]) step(vecs[i].req, vecs[i].exp);

    // Reset mid-grant with ptr=2; after reset ptr must restart at 0.
    step(4'b0100, mk(4'b0100, 2'd2, 1'b1, 1'b0));
    reset = 1'b1;
    #1;
    check("async_reset_grant", 32'(grant), 32'd0);
    check("async_reset_valid", 32'(grant_valid), 32'd0);
    check("async_reset_idx", 32'(grant_idx), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(4'b0110, mk(4'b0010, 2'd1, 1'b1, 1'b0));
    step(4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0));

`ifdef RR_GRANT_TIMEOUT_EN
    // ptr=2: requester 2 holds past TIMEOUT while 3 waits.
    for (int c = 0; c < TO; c++) step(4'b1100, mk(4'b0100, 2'd2, 1'b1, 1'b0));
    step(4'b1100, mk(4'b0000, 2'd0, 1'b0, 1'b1));
    step(4'b1100, mk(4'b1000, 2'd3, 1'b1, 1'b0));
    // 3 releases (ptr=0); 2 still held without a drop so it stays blocked.
    step(4'b0100, mk(4'b0000, 2'd0, 1'b0, 1'b0));
    step(4'b0100, mk(4'b0000, 2'd0, 1'b0, 1'b0));
    step(4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0));
    step(4'b0100, mk(4'b0100, 2'd2, 1'b1, 1'b0));
    step(4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter that shares one decoded resource select among `N` requesters. It samples a request vector, picks one winner fairly, and holds the grant until the winner releases it. The grant is driven as a registered index plus a one-hot select, which feeds the enable/select decode of the shared datapath. The block sits between requesting agents and the decoder-driven resource.

## Interface
- `N`, 4: number of requesters (2..16).
- `IW`, `$clog2(N)`: width of the grant index.
- `TIMEOUT`, 64: maximum grant hold in cycles. Used only when `RR_GRANT_TIMEOUT_EN` is defined.
- `clk`  in  1  sole clock. Rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `req`  in  N  level request. Bit i is held high by requester i until it is finished.
- `grant`  out  N  one-hot grant. All zero when idle.
- `grant_idx`  out  IW  index of the current winner. Valid only when `grant_valid` is high.
- `grant_valid`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse on forced release. Present only with `RR_GRANT_TIMEOUT_EN`.

## Operation
- FSM states:
  - `IDLE`: no grant.
  - `BUSY`: grant held.
- Priority pointer `ptr` (IW bits) names the highest-priority requester. Search order is `ptr`, `ptr+1`, … `N-1`, `0`, … `ptr-1`.
- `IDLE` → `BUSY`:
  - Taken when `req != 0`.
  - Latch the first set bit in search order as `grant_idx`.
  - `grant = 1 << grant_idx`; `grant_valid = 1`.
- `BUSY` → `IDLE`:
  - Taken when `req[grant_idx] == 0` (release).
  - `ptr <= (grant_idx + 1) mod N`; wrap from `N-1` to `0`.
  - `grant` and `grant_valid` clear.
- `BUSY` with `req[grant_idx] == 1`: hold. Requests on other bits are ignored; there is no preemption.
- `req == 0` in `IDLE`: stay idle; `ptr` is unchanged.
- A requester that drops its bit before it is granted is simply never granted. No request memory.
- `grant` is produced by an index-to-one-hot decode gated by `grant_valid`. It must never have more than one bit set.
- Reset values: state `IDLE`, `ptr = 0`, `grant = 0`, `grant_idx = 0`, `grant_valid = 0`, `timeout = 0`.
- Reset asserted mid-grant: all outputs clear asynchronously. After deassertion, arbitration restarts from `ptr = 0`.

## Timing
- All outputs are registered.
- Request-to-grant latency: `req` seen high at edge k in `IDLE` → `grant` valid after edge k.
- Release latency: `req[grant_idx]` low at edge k → `grant` zero after edge k.
- Minimum one idle cycle between consecutive grants. Handoff from one requester to the next takes 2 cycles: release edge, then arbitration edge.
- Worst-case wait for a requester holding `req` high: N−1 complete grants of the others.

## Configuration
- `RR_GRANT_TIMEOUT_EN` defined:
  - A hold counter of `$clog2(TIMEOUT+1)` bits clears on entry to `BUSY` and increments each `BUSY` cycle.
  - When the count reaches `TIMEOUT−1` with the request still held, the next edge forces `BUSY` → `IDLE`, advances `ptr` as on a normal release, and pulses `timeout` for one cycle.
  - A release and a timeout in the same cycle count as a release: no pulse.
  - The forced-off requester must drop and re-raise `req` before it can compete again. A `blocked` flag clears when that bit goes low.
- `RR_GRANT_TIMEOUT_EN` undefined: no counter, no `timeout` port, and the grant is held indefinitely.

## Structure
- Package `rr_grant_pkg`:
  - state enum `{IDLE, BUSY}`
  - default `N` and `TIMEOUT` constants
  - function `rr_pick(req, ptr)` returning the winning index
- Sub-module `rr_onehot_dec`: parameterised index+enable to one-hot decoder (N outputs) that drives `grant`.

## Test plan
- Reset, then `req=4'b0000` for 5 cycles → `grant=0`, `grant_valid=0`, `ptr=0`.
- `req=4'b1010` → `grant=4'b0010`, `grant_idx=1`. Drop `req[1]` → idle cycle, then `grant=4'b1000`, `grant_idx=3`.
- `req=4'b1111` held and each winner released after 3 cycles → grant order 0, 1, 2, 3, 0, with exactly one idle cycle between grants.
- Winner 3 releases → `ptr` wraps to 0; `req=4'b0001` → `grant=4'b0001`.
- Assert `reset` mid-grant (`grant=4'b0100`) → outputs zero immediately. After reset, `req=4'b0110` → `grant_idx=1`.
- With `RR_GRANT_TIMEOUT_EN`, `TIMEOUT=8`, `req[2]` held → `grant[2]` for 8 cycles, then `timeout` pulses once, and `grant_idx=3` next if `req[3]` is pending.
